alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have port `start`, input, 1 bit: request to execute one operation on the current operands.
REQ-004 The module SHALL have port `ALUin1`, input, 32 bits: first operand, from the operand-select stage.
REQ-005 The module SHALL have port `ALUin2`, input, 32 bits: second operand, from the operand-select stage.
REQ-006 The module SHALL have port `ALUOp`, input, 4 bits: operation code.
REQ-007 The module SHALL have port `busy`, output, 1 bit: an operation is in progress.
REQ-008 The module SHALL have port `done`, output, 1 bit: one-cycle pulse; `result` and the flags are valid.
REQ-009 The module SHALL have port `result`, output, 32 bits: registered ALU output.
REQ-010 The module SHALL have port `zero`, output, 1 bit: `result == 0`.
REQ-011 The module SHALL have port `sign`, output, 1 bit: `result[31]`.
REQ-012 The module SHALL have port `carry`, output, 1 bit: carry out of bit 31 for ADD and SUB; 0 for all other opcodes.
REQ-013 The module SHALL have port `overflow`, output, 1 bit: two's-complement overflow for ADD and SUB; 0 for all other opcodes.

Function
REQ-014 `ALUOp` encoding SHALL be:
- 0 ADD
- 1 SUB (in1 − in2)
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT (~in1)
- 6 SLA
- 7 SRA
- 8 SRL
- 9 INC (in1+1)
- 10 DEC (in1−1)
- 11–15 reserved: result 0.
REQ-015 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, and SHALL be in IDLE after reset.
REQ-016 `start` SHALL be sampled only in IDLE or DONE; `start` while in SHIFT SHALL be ignored without affecting the operation in progress.
REQ-017 On an accepted `start`, the operands and `ALUOp` SHALL be captured on the same edge; later operand changes SHALL have no effect on the operation.
REQ-018 Non-shift opcodes, and shifts with `ALUin2[4:0]==0`, SHALL register the result and flags on the accepting edge E0, go to DONE, and assert `done` in the following cycle (latency 1).
REQ-019 Shift opcodes with k = `ALUin2[4:0]` > 0 SHALL enter SHIFT with count = k and work register = in1.
REQ-019a In SHIFT, each edge SHALL shift the work register by one bit and decrement the count; the edge on which the count goes 1→0 SHALL go to DONE, so `done` appears after edge E0+k.
REQ-020 Shift amount SHALL use only `ALUin2[4:0]`; bits [31:5] SHALL be ignored.
REQ-021 Shift fill rules:
- SLA: shift left, 0 fill.
- SRA: shift right, replicate bit 31.
- SRL: shift right, 0 fill.
REQ-022 ADD/SUB arithmetic:
- ADD: carry = bit 32 of the 33-bit sum in1+in2.
- SUB: computed as in1 + ~in2 + 1; carry = bit 32 of that sum (1 means no borrow).
- overflow for both = operands (after inversion for SUB) have the same sign and the result sign differs.
REQ-023 INC and DEC SHALL wrap modulo 2^32 (0xFFFFFFFF+1 = 0, 0−1 = 0xFFFFFFFF), with carry=0 and overflow=0.
REQ-024 `busy` SHALL be 1 exactly while in SHIFT.
REQ-025 `done` SHALL be 1 exactly while in DONE, for one cycle only.
REQ-026 From DONE, the FSM SHALL return to IDLE unless `start` is 1, in which case the new operation SHALL be accepted on that edge (back-to-back ops).
REQ-027 `result` and all flags SHALL hold their last values until the next completing operation; during SHIFT they SHALL keep the previous operation's values.

Reset
REQ-028 While `rst_n`=0, immediately and independent of `clk`, the FSM SHALL be in IDLE and `busy`, `done`, `result`, `carry`, `overflow` and `sign` SHALL be 0, with `zero`=1.
REQ-029 Reset asserted mid-SHIFT SHALL abandon the operation, produce no `done` pulse, and leave no residual count.
REQ-030 The first rising edge with `rst_n`=1 SHALL be able to accept `start`.

Verification
REQ-031 The bench SHALL check: ADD 0x7FFFFFFF+0x00000001 → after 1 cycle, done=1, result=0x80000000, overflow=1, carry=0, sign=1, zero=0.
REQ-032 The bench SHALL check: SUB 5−5 → result=0, zero=1, carry=1; SUB 3−5 → result=0xFFFFFFFE, carry=0, sign=1.
REQ-033 The bench SHALL check: SRA in1=0x80000010, in2=4 → busy=1 for 4 cycles, done after edge E0+4, result=0xF8000001; `start` pulsed mid-shift is ignored.
REQ-034 The bench SHALL check: SLA in2=0x00000020 (amount 0) → latency 1, result=in1; SRL in1=0xFFFFFFFF, in2=31 → result=0x00000001 after 31 shift cycles.
REQ-035 The bench SHALL check back-to-back: `start` held during the DONE cycle of an AND, then an INC on 0xFFFFFFFF → result=0, zero=1, carry=0, with no idle cycle between the two done pulses.
REQ-036 The bench SHALL check: `rst_n` dropped between clock edges during a k=20 shift → outputs immediately go to reset values, no `done` pulse follows, and the next op completes normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle arithmetic/logic ops, bit-serial shifts.
// Three-state controller (IDLE/SHIFT/DONE) with registered result and flags.
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] ALUin1,
    input  logic [DATA_W-1:0] ALUin2,
    input  logic [3:0]        ALUOp,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              sign,
    output logic              carry,
    output logic              overflow
);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SLA = 4'd6, OP_SRA = 4'd7,
                           OP_SRL = 4'd8, OP_INC = 4'd9, OP_DEC = 4'd10;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [4:0]         cnt;
    logic [3:0]         op_q;
    logic [DATA_W-1:0]  work;
    logic               accept, shift_req, last_shift;
    logic [DATA_W+1:0]  eval;
    logic [DATA_W-1:0]  work_step;

    // Returns {overflow, carry, result}; shift opcodes land here only with amount 0.
    function automatic logic [DATA_W+1:0] alu_eval(input logic [3:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
        logic [DATA_W:0]          sum;
        logic signed [DATA_W-1:0] bx;
        logic [DATA_W+1:0]        r;
        r   = '0;
        sum = '0;
        bx  = b;
        case (op)
            OP_ADD, OP_SUB: begin
                bx  = (op == OP_SUB) ? ~b : b;
                sum = {1'b0, a} + {1'b0, bx} + {{DATA_W{1'b0}}, (op == OP_SUB)};
                r   = {(a[DATA_W-1] == bx[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]), sum};
            end
            OP_AND: r[DATA_W-1:0] = a & b;
            OP_OR:  r[DATA_W-1:0] = a | b;
            OP_XOR: r[DATA_W-1:0] = a ^ b;
            OP_NOT: r[DATA_W-1:0] = ~a;
            OP_SLA, OP_SRA, OP_SRL: r[DATA_W-1:0] = a;
            OP_INC: r[DATA_W-1:0] = a + 1'b1;
            OP_DEC: r[DATA_W-1:0] = a - 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] shift_one(input logic [3:0] op,
                                                    input logic signed [DATA_W-1:0] w);
        case (op)
            OP_SLA:  return {w[DATA_W-2:0], 1'b0};
            OP_SRA:  return w >>> 1;
            OP_SRL:  return {1'b0, w[DATA_W-1:1]};
            default: return w;
        endcase
    endfunction

    assign accept     = start && (state != SHIFT);
    assign shift_req  = (ALUOp == OP_SLA || ALUOp == OP_SRA || ALUOp == OP_SRL) && (ALUin2[4:0] != 5'd0);
    assign last_shift = (state == SHIFT) && (cnt == 5'd1);
    assign eval       = alu_eval(ALUOp, ALUin1, ALUin2);
    assign work_step  = shift_one(op_q, work);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = shift_req ? SHIFT : DONE;
                else        state_nxt = IDLE;
            end
            SHIFT:   if (last_shift) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            work     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= ALUOp;
                work <= ALUin1;
                cnt  <= shift_req ? ALUin2[4:0] : 5'd0;
                if (!shift_req) begin
                    {overflow, carry, result} <= eval;
                end
            end else if (state == SHIFT) begin
                work <= work_step;
                cnt  <= cnt - 5'd1;
                if (last_shift) begin
                    result   <= work_step;
                    carry    <= 1'b0;
                    overflow <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign zero = (result == '0);
    assign sign = result[DATA_W-1];

endmodule
